// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-state issue/writeback controller for an external 8-bit ALU.
// Accepts one instruction at a time, drives ALU operands from a 4x8 register file,
// captures the result, and writes it back when the result port transfers.
module alu_issue_ctrl #(
   parameter logic [7:0] REG_RESET  = 8'h00,
   parameter bit         ILLEGAL_WB = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [13:0] instr,
   output logic [7:0]  alu_in1,
   output logic [7:0]  alu_in2,
   output logic [2:0]  alu_op,
   output logic [5:0]  alu_imm6,
   output logic        alu_imm_mode,
   input  logic [7:0]  alu_out,
   input  logic        alu_zero,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [7:0]  res_data,
   output logic        res_zero,
   output logic [1:0]  res_rd,
   output logic        err_illegal,
   input  logic [1:0]  dbg_addr,
   output logic [7:0]  dbg_data
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DECODE = 2'd1;
   localparam logic [1:0] ST_EXEC   = 2'd2;
   localparam logic [1:0] ST_WB     = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [13:0] instr_q;
   logic [7:0]  alu_in1_q, alu_in2_q;
   logic [2:0]  alu_op_q;
   logic [5:0]  alu_imm6_q;
   logic        alu_imm_mode_q;
   logic [7:0]  res_data_q;
   logic        res_zero_q;
   logic [1:0]  res_rd_q;
   logic        err_illegal_q;
   logic [7:0]  rf_q [4];

   // Fields of the latched instruction
   logic [2:0] dec_op;
   logic       dec_imm_mode;
   logic [1:0] dec_rd, dec_rs1, dec_rs2;
   logic [5:0] dec_imm6;
   logic       wb_en;

   assign dec_op       = instr_q[13:11];
   assign dec_imm_mode = instr_q[10];
   assign dec_rd       = instr_q[9:8];
   assign dec_rs1      = instr_q[7:6];
   assign dec_imm6     = instr_q[5:0];
   assign dec_rs2      = instr_q[1:0];

   // Register write happens only on the result-port transfer; illegal ops may be suppressed
   assign wb_en = (state_q == ST_WB) && res_ready && (!dec_op[2] || ILLEGAL_WB);

   // Next-state logic: one pass through DECODE/EXEC, WB waits for the consumer
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC:   state_d = ST_WB;
         ST_WB:     if (res_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Datapath: latch instruction, drive the ALU, capture its result, track illegal ops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q        <= '0;
         alu_in1_q      <= '0;
         alu_in2_q      <= '0;
         alu_op_q       <= '0;
         alu_imm6_q     <= '0;
         alu_imm_mode_q <= 1'b0;
         res_data_q     <= '0;
         res_zero_q     <= 1'b0;
         res_rd_q       <= '0;
         err_illegal_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (instr_valid) instr_q <= instr;
            end
            ST_DECODE: begin
               alu_in1_q      <= rf_q[dec_rs1];
               alu_in2_q      <= rf_q[dec_rs2];
               alu_op_q       <= dec_op;
               alu_imm6_q     <= dec_imm6;
               alu_imm_mode_q <= dec_imm_mode;
            end
            ST_EXEC: begin
               res_data_q <= alu_out;
               res_zero_q <= alu_zero;
               res_rd_q   <= dec_rd;
               if (dec_op[2]) err_illegal_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Register file: one flop bank per entry, written back from the captured result
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_rf
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                              rf_q[gi] <= REG_RESET;
            else if (wb_en && (res_rd_q == 2'(gi)))  rf_q[gi] <= res_data_q;
         end
      end
   endgenerate

   assign instr_ready  = (state_q == ST_IDLE);
   assign res_valid    = (state_q == ST_WB);
   assign alu_in1      = alu_in1_q;
   assign alu_in2      = alu_in2_q;
   assign alu_op       = alu_op_q;
   assign alu_imm6     = alu_imm6_q;
   assign alu_imm_mode = alu_imm_mode_q;
   assign res_data     = res_data_q;
   assign res_zero     = res_zero_q;
   assign res_rd       = res_rd_q;
   assign err_illegal  = err_illegal_q;
   assign dbg_data     = rf_q[dbg_addr];

endmodule
